// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg: shared clear-FSM state type and SRAM macro geometry for the
// banked framebuffer.
package framebuffer_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

   localparam int unsigned MACRO_WIDTH = 16;
   localparam int unsigned MACRO_DEPTH = 1024;
   localparam int unsigned MACRO_ROW_W = $clog2(MACRO_DEPTH);

   function automatic int unsigned banks_for_words(input int unsigned words);
      return (words + MACRO_DEPTH - 1) / MACRO_DEPTH;
   endfunction
endpackage

// File: rtl/RM_IHPSG13_2P_1024x16_c2_bm_bist.sv
// Behavioural model of the two-port 1024x16 bit-masked SRAM macro.
// Both ports are modelled on A_CLK; the framebuffer drives them from one clock.
module RM_IHPSG13_2P_1024x16_c2_bm_bist (
   input  logic        A_CLK, A_MEN, A_WEN, A_REN, A_DLY,
   input  logic [9:0]  A_ADDR,
   input  logic [15:0] A_DIN, A_BM,
   output logic [15:0] A_DOUT,
   input  logic        A_BIST_CLK, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
   input  logic [9:0]  A_BIST_ADDR,
   input  logic [15:0] A_BIST_DIN, A_BIST_BM,
   input  logic        B_CLK, B_MEN, B_WEN, B_REN, B_DLY,
   input  logic [9:0]  B_ADDR,
   input  logic [15:0] B_DIN, B_BM,
   output logic [15:0] B_DOUT,
   input  logic        B_BIST_CLK, B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN,
   input  logic [9:0]  B_BIST_ADDR,
   input  logic [15:0] B_BIST_DIN, B_BIST_BM
);
   logic [15:0] mem_q [1024];

   logic unused_tie;
   assign unused_tie = ^{A_DLY, A_BIST_CLK, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                         A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, B_CLK, B_DLY, B_BIST_CLK,
                         B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR,
                         B_BIST_DIN, B_BIST_BM};

   always_ff @(posedge A_CLK) begin
      if (A_MEN && A_WEN) mem_q[A_ADDR] <= (mem_q[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
      if (B_MEN && B_WEN) mem_q[B_ADDR] <= (mem_q[B_ADDR] & ~B_BM) | (B_DIN & B_BM);
      if (A_MEN && A_REN) A_DOUT <= mem_q[A_ADDR];
      if (B_MEN && B_REN) B_DOUT <= mem_q[B_ADDR];
   end
endmodule

// File: rtl/framebuffer_bank.sv
// framebuffer_bank: one two-port SRAM macro with per-port select/write/mask,
// memory enable and delay tied high, BIST port tied off.
module framebuffer_bank
   import framebuffer_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   selA_i,
   input  logic                   writeA_i,
   input  logic [MACRO_WIDTH-1:0] maskA_i,
   input  logic [MACRO_ROW_W-1:0] rowA_i,
   input  logic [MACRO_WIDTH-1:0] dinA_i,
   output logic [MACRO_WIDTH-1:0] doutA_o,
   input  logic                   selB_i,
   input  logic                   writeB_i,
   input  logic [MACRO_WIDTH-1:0] maskB_i,
   input  logic [MACRO_ROW_W-1:0] rowB_i,
   input  logic [MACRO_WIDTH-1:0] dinB_i,
   output logic [MACRO_WIDTH-1:0] doutB_o
);
   RM_IHPSG13_2P_1024x16_c2_bm_bist u_macro (
      .A_CLK(clk_i), .A_MEN(1'b1), .A_WEN(selA_i & writeA_i), .A_REN(selA_i & ~writeA_i),
      .A_DLY(1'b1), .A_ADDR(rowA_i), .A_DIN(dinA_i), .A_BM(maskA_i), .A_DOUT(doutA_o),
      .A_BIST_CLK(1'b0), .A_BIST_EN(1'b0), .A_BIST_MEN(1'b0), .A_BIST_WEN(1'b0),
      .A_BIST_REN(1'b0), .A_BIST_ADDR('0), .A_BIST_DIN('0), .A_BIST_BM('0),
      .B_CLK(clk_i), .B_MEN(1'b1), .B_WEN(selB_i & writeB_i), .B_REN(selB_i & ~writeB_i),
      .B_DLY(1'b1), .B_ADDR(rowB_i), .B_DIN(dinB_i), .B_BM(maskB_i), .B_DOUT(doutB_o),
      .B_BIST_CLK(1'b0), .B_BIST_EN(1'b0), .B_BIST_MEN(1'b0), .B_BIST_WEN(1'b0),
      .B_BIST_REN(1'b0), .B_BIST_ADDR('0), .B_BIST_DIN('0), .B_BIST_BM('0)
   );
endmodule

// File: rtl/banked_framebuffer.sv
// banked_framebuffer: dual-port framebuffer over NUM_BANKS SRAM macros with registered
// per-port read muxes. Hardware clear engine built when BANKED_FRAMEBUFFER_CLEAR_EN is defined.
module banked_framebuffer
   import framebuffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BANK_DEPTH = 1024,
   parameter int unsigned NUM_BANKS  = 3,
   parameter int unsigned ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enableA,
   input  logic                  writeEnableA,
   input  logic [ADDR_WIDTH-1:0] addressA,
   input  logic [DATA_WIDTH-1:0] dataInA,
   input  logic [DATA_WIDTH-1:0] bitMaskA,
   output logic [DATA_WIDTH-1:0] dataOutA,
   output logic                  readValidA,
   output logic                  rangeErrorA,
   input  logic                  enableB,
   input  logic                  writeEnableB,
   input  logic [ADDR_WIDTH-1:0] addressB,
   input  logic [DATA_WIDTH-1:0] dataInB,
   output logic [DATA_WIDTH-1:0] dataOutB,
   output logic                  readValidB,
   output logic                  rangeErrorB,
   input  logic                  clearStart,
   input  logic [DATA_WIDTH-1:0] clearColor,
   output logic                  busy,
   output logic                  clearDone
);
   localparam int unsigned ROW_W = $clog2(BANK_DEPTH);
   localparam int unsigned SEL_W = ADDR_WIDTH - ROW_W;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_BANKS * BANK_DEPTH);

   logic                  clr_busy;
   logic [ROW_W-1:0]      clr_row;
   logic [DATA_WIDTH-1:0] clr_color;

`ifdef BANKED_FRAMEBUFFER_CLEAR_EN
   clr_state_e            state_q;
   logic [ROW_W-1:0]      row_q;
   logic [DATA_WIDTH-1:0] color_q;
   logic                  busy_q, done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         color_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (clearStart) begin
                  state_q <= CLEAR;
                  color_q <= clearColor;
                  row_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               row_q <= row_q + ROW_W'(1);
               if (row_q == ROW_W'(BANK_DEPTH - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_busy  = busy_q;
   assign clr_row   = row_q;
   assign clr_color = color_q;
   assign busy      = busy_q;
   assign clearDone = done_q;
`else
   logic unused_clear;
   assign unused_clear = ^{clearStart, clearColor};
   assign clr_busy  = 1'b0;
   assign clr_row   = '0;
   assign clr_color = '0;
   assign busy      = 1'b0;
   assign clearDone = 1'b0;
`endif

   logic             reqA, inA, rdA_d, reqB, inB, rdB_d;
   logic [SEL_W-1:0] bankA, bankB;

   assign reqA  = enableA & ~clr_busy;
   assign inA   = {1'b0, addressA} < LIMIT;
   assign bankA = addressA[ADDR_WIDTH-1:ROW_W];
   assign rdA_d = reqA & ~writeEnableA;
   assign reqB  = enableB;
   assign inB   = {1'b0, addressB} < LIMIT;
   assign bankB = addressB[ADDR_WIDTH-1:ROW_W];
   assign rdB_d = reqB & ~writeEnableB;

   // Selects only move on reads so dataOut holds the last read word between reads.
   logic [SEL_W-1:0] selA_q, selB_q;
   logic             inA_q, inB_q, validA_q, validB_q, errA_q, errB_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         selA_q   <= '0;
         selB_q   <= '0;
         inA_q    <= 1'b0;
         inB_q    <= 1'b0;
         validA_q <= 1'b0;
         validB_q <= 1'b0;
         errA_q   <= 1'b0;
         errB_q   <= 1'b0;
      end else begin
         validA_q <= rdA_d;
         validB_q <= rdB_d;
         errA_q   <= reqA & ~inA;
         errB_q   <= reqB & ~inB;
         if (rdA_d) begin
            selA_q <= bankA;
            inA_q  <= inA;
         end
         if (rdB_d) begin
            selB_q <= bankB;
            inB_q  <= inB;
         end
      end
   end

   logic [DATA_WIDTH-1:0] doutA [NUM_BANKS];
   logic [DATA_WIDTH-1:0] doutB [NUM_BANKS];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      framebuffer_bank u_bank (
         .clk_i   (clk),
         .selA_i  (clr_busy | (reqA & inA & (bankA == SEL_W'(b)))),
         .writeA_i(clr_busy | writeEnableA),
         .maskA_i (clr_busy ? '1 : bitMaskA),
         .rowA_i  (clr_busy ? clr_row : addressA[ROW_W-1:0]),
         .dinA_i  (clr_busy ? clr_color : dataInA),
         .doutA_o (doutA[b]),
         .selB_i  (reqB & inB & (bankB == SEL_W'(b))),
         .writeB_i(writeEnableB),
         .maskB_i ('1),
         .rowB_i  (addressB[ROW_W-1:0]),
         .dinB_i  (dataInB),
         .doutB_o (doutB[b])
      );
   end

   always_comb begin
      dataOutA = '0;
      dataOutB = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         if (inA_q && selA_q == SEL_W'(i)) dataOutA = doutA[i];
         if (inB_q && selB_q == SEL_W'(i)) dataOutB = doutB[i];
      end
   end

   assign readValidA  = validA_q;
   assign readValidB  = validB_q;
   assign rangeErrorA = errA_q;
   assign rangeErrorB = errB_q;
endmodule

// File: tb/tb_banked_framebuffer.sv
// tb_banked_framebuffer: directed vector table, random dual-port traffic against a flat
// word-array model, and clear-engine sequences when BANKED_FRAMEBUFFER_CLEAR_EN is defined.
module tb_banked_framebuffer;
   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 17;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned NB    = 3;
   localparam int unsigned WORDS = NB * DEPTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          enableA, writeEnableA, enableB, writeEnableB;
   logic [AW-1:0] addressA, addressB;
   logic [DW-1:0] dataInA, bitMaskA, dataInB, dataOutA, dataOutB;
   logic          readValidA, rangeErrorA, readValidB, rangeErrorB;
   logic          clearStart;
   logic [DW-1:0] clearColor;
   logic          busy, clearDone;

   always #5 clk = ~clk;

   banked_framebuffer #(.DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .NUM_BANKS(NB), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .enableA(enableA), .writeEnableA(writeEnableA), .addressA(addressA), .dataInA(dataInA),
      .bitMaskA(bitMaskA), .dataOutA(dataOutA), .readValidA(readValidA), .rangeErrorA(rangeErrorA),
      .enableB(enableB), .writeEnableB(writeEnableB), .addressB(addressB), .dataInB(dataInB),
      .dataOutB(dataOutB), .readValidB(readValidB), .rangeErrorB(rangeErrorB),
      .clearStart(clearStart), .clearColor(clearColor), .busy(busy), .clearDone(clearDone)
   );

   typedef struct packed {
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] mask;
   } op_t;

   typedef struct {
      op_t           a;
      op_t           b;
      logic          va, ea;
      logic [DW-1:0] da;
      logic          vb, eb;
      logic [DW-1:0] db;
   } vec_t;

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;
   logic [DW-1:0] model [2**AW];
   vec_t          tbl [19];

   function automatic op_t nop();
      op_t o;
      o = '0;
      return o;
   endfunction

   function automatic op_t rd(input logic [AW-1:0] ad);
      op_t o;
      o = '0;
      o.en = 1'b1;
      o.addr = ad;
      return o;
   endfunction

   function automatic op_t wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [DW-1:0] m);
      op_t o;
      o.en = 1'b1;
      o.we = 1'b1;
      o.addr = ad;
      o.din = d;
      o.mask = m;
      return o;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input op_t a, input op_t b);
      enableA = a.en; writeEnableA = a.we; addressA = a.addr; dataInA = a.din; bitMaskA = a.mask;
      enableB = b.en; writeEnableB = b.we; addressB = b.addr; dataInB = b.din;
   endtask

   task automatic model_write(input op_t a, input op_t b, input logic blockA);
      if (a.en && a.we && !blockA && 32'(a.addr) < WORDS)
         model[a.addr] = (model[a.addr] & ~a.mask) | (a.din & a.mask);
      if (b.en && b.we && 32'(b.addr) < WORDS)
         model[b.addr] = b.din;
   endtask

   // One cycle of traffic; expectations come from the model state before the edge.
   task automatic step_checked(input op_t a, input op_t b, input logic blockA);
      logic          ev_a, ee_a, ev_b, ee_b;
      logic [DW-1:0] ed_a, ed_b;
      ev_a = a.en && !a.we && !blockA;
      ee_a = a.en && !blockA && 32'(a.addr) >= WORDS;
      ed_a = (32'(a.addr) < WORDS) ? model[a.addr] : '0;
      ev_b = b.en && !b.we;
      ee_b = b.en && 32'(b.addr) >= WORDS;
      ed_b = (32'(b.addr) < WORDS) ? model[b.addr] : '0;
      drive(a, b);
      tick();
      check1("readValidA", readValidA, ev_a);
      check1("rangeErrorA", rangeErrorA, ee_a);
      if (ev_a) check16($sformatf("dataOutA[%h]", a.addr), dataOutA, ed_a);
      check1("readValidB", readValidB, ev_b);
      check1("rangeErrorB", rangeErrorB, ee_b);
      if (ev_b) check16($sformatf("dataOutB[%h]", b.addr), dataOutB, ed_b);
      model_write(a, b, blockA);
   endtask

   task automatic sweep(input logic skip_partial);
      for (int unsigned w = 0; w < WORDS; w++) begin
         if (skip_partial && ((w % DEPTH) == 299 || (w % DEPTH) == 300)) continue;
         step_checked(rd(AW'(w)), nop(), 1'b0);
      end
   endtask

   task automatic fill_random();
      for (int unsigned w = 0; w < WORDS; w++)
         step_checked(nop(), wr(AW'(w), DW'($urandom), '1), 1'b0);
   endtask

`ifdef BANKED_FRAMEBUFFER_CLEAR_EN
   // Cycle 0 carries clearStart; cycle k (1..DEPTH) clears row k-1 in every bank.
   task automatic clear_run(input logic [DW-1:0] color, input int unsigned reset_at);
      op_t a, b;
      clearStart = 1'b1;
      clearColor = color;
      step_checked(nop(), nop(), 1'b0);
      clearStart = 1'b0;
      clearColor = '0;
      check1("busy@1", busy, 1'b1);
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         if (k == reset_at) begin
            reset = 1'b1;
            drive(nop(), nop());
            tick();
            reset = 1'b0;
            for (int unsigned w = 0; w < NB; w++) model[AW'(w * DEPTH + k - 1)] = color;
            check1("busy after reset", busy, 1'b0);
            check1("clearDone after reset", clearDone, 1'b0);
            check1("readValidB after reset", readValidB, 1'b0);
            return;
         end
         clearStart = (k == 500);
         clearColor = 16'h0F0F;
         a = ((k % 4) == 0) ? rd(17'h1F000) : wr(AW'($urandom_range(WORDS - 1)), 16'h0BAD, 16'hFFFF);
         b = (k >= 2) ? rd(AW'((k % NB) * DEPTH + k - 2)) : nop();
         step_checked(a, b, 1'b1);
         clearStart = 1'b0;
         for (int unsigned w = 0; w < NB; w++) model[AW'(w * DEPTH + k - 1)] = color;
         check1($sformatf("busy@%0d", k + 1), busy, (k + 1 <= DEPTH));
         check1($sformatf("clearDone@%0d", k + 1), clearDone, (k + 1 == DEPTH + 1));
      end
      drive(nop(), nop());
      tick();
      check1("clearDone after DONE", clearDone, 1'b0);
      check1("busy after DONE", busy, 1'b0);
   endtask
`endif

   initial begin
      op_t a, b;
      reset = 1'b1;
      clearStart = 1'b0;
      clearColor = '0;
      drive(nop(), nop());
      tick();
      tick();
      check16("reset dataOutA", dataOutA, '0);
      check16("reset dataOutB", dataOutB, '0);
      check1("reset readValidA", readValidA, 1'b0);
      check1("reset readValidB", readValidB, 1'b0);
      check1("reset rangeErrorA", rangeErrorA, 1'b0);
      check1("reset rangeErrorB", rangeErrorB, 1'b0);
      check1("reset busy", busy, 1'b0);
      check1("reset clearDone", clearDone, 1'b0);
      reset = 1'b0;

      fill_random();

      tbl[0]  = '{wr(17'h00005, 16'h1234, 16'hFFFF), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[1]  = '{wr(17'h00405, 16'hBEEF, 16'hFFFF), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[2]  = '{wr(17'h00805, 16'h00FF, 16'hFFFF), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[3]  = '{nop(), rd(17'h00005), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h1234};
      tbl[4]  = '{nop(), rd(17'h00405), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'hBEEF};
      tbl[5]  = '{nop(), rd(17'h00805), 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h00FF};
      tbl[6]  = '{wr(17'h00000, 16'h1111, 16'hFFFF), wr(17'h00400, 16'h2222, 16'h0),
                  1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[7]  = '{wr(17'h00800, 16'h3333, 16'hFFFF), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[8]  = '{rd(17'h00000), rd(17'h00800), 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h3333};
      tbl[9]  = '{rd(17'h00400), rd(17'h00800), 1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 16'h3333};
      tbl[10] = '{rd(17'h00000), rd(17'h00800), 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h3333};
      tbl[11] = '{wr(17'h00010, 16'h1200, 16'hFFFF), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[12] = '{wr(17'h00010, 16'hFFFF, 16'h00F0), nop(), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[13] = '{rd(17'h00010), nop(), 1'b1, 1'b0, 16'h12F0, 1'b0, 1'b0, 16'h0};
      tbl[14] = '{wr(17'h00C00, 16'hDEAD, 16'hFFFF), wr(17'h00BFF, 16'h7777, 16'h0),
                  1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0};
      tbl[15] = '{rd(17'h00C00), rd(17'h00BFF), 1'b1, 1'b1, 16'h0, 1'b1, 1'b0, 16'h7777};
      tbl[16] = '{rd(17'h1FFFF), rd(17'h00C00), 1'b1, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0};
      tbl[17] = '{nop(), wr(17'h00C01, 16'h5555, 16'h0), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0};
      tbl[18] = '{rd(17'h00005), rd(17'h00405), 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'hBEEF};

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].a, tbl[i].b);
         tick();
         check1($sformatf("tbl%0d readValidA", i), readValidA, tbl[i].va);
         check1($sformatf("tbl%0d rangeErrorA", i), rangeErrorA, tbl[i].ea);
         if (tbl[i].va) check16($sformatf("tbl%0d dataOutA", i), dataOutA, tbl[i].da);
         check1($sformatf("tbl%0d readValidB", i), readValidB, tbl[i].vb);
         check1($sformatf("tbl%0d rangeErrorB", i), rangeErrorB, tbl[i].eb);
         if (tbl[i].vb) check16($sformatf("tbl%0d dataOutB", i), dataOutB, tbl[i].db);
         model_write(tbl[i].a, tbl[i].b, 1'b0);
      end

      for (int i = 0; i < 1500; i++) begin
         a.en   = 1'($urandom_range(1));
         a.we   = 1'($urandom_range(1));
         a.addr = ($urandom_range(15) == 0) ? 17'h1FFFF : AW'($urandom_range(3300));
         a.din  = DW'($urandom);
         a.mask = DW'($urandom);
         b.en   = 1'($urandom_range(1));
         b.we   = 1'($urandom_range(1));
         b.addr = AW'($urandom_range(3300));
         b.din  = DW'($urandom);
         b.mask = '1;
         if (a.en && b.en && a.addr == b.addr && (a.we || b.we)) b.en = 1'b0;
         step_checked(a, b, 1'b0);
      end

`ifdef BANKED_FRAMEBUFFER_CLEAR_EN
      clear_run(16'hA5A5, 0);
      sweep(1'b0);
      fill_random();
      clear_run(16'hA5A5, 300);
      for (int i = 0; i < 1100; i++) begin
         drive(nop(), nop());
         tick();
         check1("busy idle after reset", busy, 1'b0);
         check1("clearDone idle after reset", clearDone, 1'b0);
      end
      sweep(1'b1);
`else
      for (int i = 0; i < 6; i++) begin
         clearStart = (i == 0);
         clearColor = 16'hA5A5;
         a = (i == 0) ? wr(17'h00123, 16'h4C4C, 16'hFFFF) : rd(AW'(17'h00123 + i - 1));
         step_checked(a, nop(), 1'b0);
         check1("busy tied low", busy, 1'b0);
         check1("clearDone tied low", clearDone, 1'b0);
      end
      clearStart = 1'b0;
      sweep(1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
